// File: rtl/s_aes_pkg.sv
// Shared S-AES constants: FSM encodings, field reduction term,
// nibble positions within a 16-bit state word, and the x2 helper.
package s_aes_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COL0 = 2'd1;
  localparam logic [1:0] ST_COL1 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [3:0] GF_POLY_LO = 4'h3;

  localparam int S00_HI = 15;
  localparam int S10_HI = 11;
  localparam int S01_HI = 7;
  localparam int S11_HI = 3;

  function automatic logic [3:0] gf_x2(input logic [3:0] x);
    gf_x2 = {x[2:0], 1'b0} ^ (x[3] ? GF_POLY_LO : 4'h0);
  endfunction

endpackage

// File: rtl/inv_mixcol_seq_if.sv
// Valid/ready bundle carrying state words into and out of
// the inverse MixColumns stage.
interface inv_mixcol_seq_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_state;
  logic        in_bypass;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_state;

  modport slave (
    input  in_valid, in_state, in_bypass, out_ready,
    output in_ready, out_valid, out_state
  );

  modport master (
    output in_valid, in_state, in_bypass, out_ready,
    input  in_ready, out_valid, out_state
  );

endinterface

// File: rtl/inv_mixcol_seq_gf.sv
// GF(2^4) constant multipliers, polynomial x^4+x+1.
// gf9 computes 9*x as x ^ 8*x.
module gf2
  import s_aes_pkg::*;
(
  input  logic [3:0] a,
  output logic [3:0] y
);

  assign y = gf_x2(a);

endmodule

module gf9
  import s_aes_pkg::*;
(
  input  logic [3:0] a,
  output logic [3:0] y
);

  assign y = a ^ gf_x2(gf_x2(gf_x2(a)));

endmodule

// File: rtl/inv_mixcol_seq.sv
// Sequential S-AES inverse MixColumns: one column per cycle
// through a shared {9,2;2,9} datapath, valid/ready on both sides.
module inv_mixcol_seq
  import s_aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  inv_mixcol_seq_if.slave        bus
);

  logic [1:0]  state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [15:0] out_q, out_d;

  logic        col1;
  logic [3:0]  a, b;
  logic [3:0]  a9, a2, b9, b2;
  logic [7:0]  res;

  // Column mux: COL1 feeds s01/s11, otherwise s00/s10.
  assign col1 = (state_q == ST_COL1);
  assign a    = col1 ? work_q[S01_HI -: 4] : work_q[S00_HI -: 4];
  assign b    = col1 ? work_q[S11_HI -: 4] : work_q[S10_HI -: 4];

  gf9 u_a9 (.a(a), .y(a9));
  gf2 u_a2 (.a(a), .y(a2));
  gf9 u_b9 (.a(b), .y(b9));
  gf2 u_b2 (.a(b), .y(b2));

  assign res = {a9 ^ b2, a2 ^ b9};

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    out_d   = out_q;
    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (bus.in_valid) begin
          work_d = bus.in_state;
          if (bus.in_bypass) begin
            out_d   = bus.in_state;
            state_d = ST_DONE;
          end else begin
            state_d = ST_COL0;
          end
        end
      end
      state_q == ST_COL0: begin
        out_d[15:8] = res;
        state_d     = ST_COL1;
      end
      state_q == ST_COL1: begin
        out_d[7:0] = res;
        state_d    = ST_DONE;
      end
      state_q == ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      work_q  <= 16'h0000;
      out_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_state = out_q;

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Bench for inv_mixcol_seq: directed vectors plus randomized
// traffic against a polynomial-multiply reference model.
module tb_inv_mixcol_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [15:0] exp_q[$];

  inv_mixcol_seq_if bus ();

  inv_mixcol_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int gmul(input int x, input int y);
    int p;
    int aa;
    p  = 0;
    aa = x & 15;
    for (int i = 0; i < 4; i++) begin
      if (((y >> i) & 1) != 0) p = p ^ aa;
      aa = aa << 1;
      if ((aa & 16) != 0) aa = aa ^ 19;
    end
    return p & 15;
  endfunction

  function automatic logic [15:0] model(input logic [15:0] s);
    int m[2][2];
    int r[2][2];
    int k[2][2];
    k[0][0] = 9; k[0][1] = 2;
    k[1][0] = 2; k[1][1] = 9;
    m[0][0] = s[15:12]; m[1][0] = s[11:8];
    m[0][1] = s[7:4];   m[1][1] = s[3:0];
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++)
        r[i][c] = gmul(k[i][0], m[0][c]) ^ gmul(k[i][1], m[1][c]);
    return {r[0][0][3:0], r[1][0][3:0], r[0][1][3:0], r[1][1][3:0]};
  endfunction

  task automatic send(input logic [15:0] s, input logic byp,
                      input logic [15:0] exp, input int exp_lat,
                      input string nm);
    int lat;
    bit seen;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready got=%b want=1", nm, bus.in_ready);
    end
    bus.in_valid  = 1'b1;
    bus.in_state  = s;
    bus.in_bypass = byp;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid === 1'b1) seen = 1;
    end
    total++;
    if (!seen || lat != exp_lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", nm, lat, exp_lat);
    end
    total++;
    if (bus.out_state !== exp) begin
      bad++;
      $display("FAIL %s out_state got=%h want=%h", nm, bus.out_state, exp);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_state !== 16'h0000) begin
      bad++;
      $display("FAIL reset rdy/vld/state got=%b/%b/%h want=1/0/0000",
               bus.in_ready, bus.out_valid, bus.out_state);
    end
  endtask

  task automatic test_mid_reset;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_state  = 16'h1234;
    bus.in_bypass = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_busy in_ready got=%b want=0", bus.in_ready);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out_state !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset rdy/vld/state got=%b/%b/%h want=1/0/0000",
               bus.in_ready, bus.out_valid, bus.out_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset vld/rdy got=%b/%b want=0/1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_single;
    send(16'h1000, 1'b0, 16'h9200, 3, "single_1000");
  endtask

  task automatic test_vectors;
    logic [15:0] w;
    send(16'h1234, 1'b0, 16'hD304, 3, "vec_1234");
    send(16'hFFFF, 1'b0, 16'h3333, 3, "vec_ffff");
    send(16'h0001, 1'b0, 16'h0029, 3, "vec_0001");
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      send(w, 1'b0, model(w), 3, "vec_rand");
    end
  endtask

  task automatic test_bypass;
    send(16'hA5C3, 1'b1, 16'hA5C3, 1, "bypass_a5c3");
  endtask

  task automatic test_stall;
    logic [15:0] w1;
    logic [15:0] w2;
    int cyc;
    w1 = 16'h3C5A;
    w2 = 16'h81E7;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_state  = w1;
    bus.in_bypass = 1'b0;
    @(posedge clk);
    #1 bus.in_state = w2;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.out_state !== model(w1)) begin
        bad++;
        $display("FAIL stall vld/rdy/state got=%b/%b/%h want=1/0/%h",
                 bus.out_valid, bus.in_ready, bus.out_state, model(w1));
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release vld/rdy got=%b/%b want=0/1",
               bus.out_valid, bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_state !== model(w2)) begin
      bad++;
      $display("FAIL stall_next vld/state got=%b/%h want=1/%h",
               bus.out_valid, bus.out_state, model(w2));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    exp_q.delete();
    fork
      begin : drv
        logic [15:0] w;
        logic b;
        int cyc;
        bit stuck;
        stuck = 0;
        for (int i = 0; i < 100 && !stuck; i++) begin
          w = 16'($urandom);
          b = ($urandom_range(0, 7) == 0);
          @(negedge clk);
          bus.in_valid  = 1'b1;
          bus.in_state  = w;
          bus.in_bypass = b;
          cyc = 0;
          while (bus.in_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
          end
          if (bus.in_ready !== 1'b1) begin
            stuck = 1;
            total++;
            bad++;
            $display("FAIL b2b accept timeout got=0 want=1 word=%0d", i);
          end else begin
            exp_q.push_back(b ? w : model(w));
            @(posedge clk);
          end
          #1 bus.in_valid = 1'b0;
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
      end
      begin : mon
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < 100 && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          bus.out_ready = $urandom_range(0, 1) == 1;
          if (bus.out_valid === 1'b1 && bus.out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL b2b extra output got=%h want=none", bus.out_state);
            end else begin
              if (bus.out_state !== exp_q[0]) begin
                bad++;
                $display("FAIL b2b word %0d got=%h want=%h",
                         got, bus.out_state, exp_q[0]);
              end
              void'(exp_q.pop_front());
            end
            got++;
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        total++;
        if (got != 100) begin
          bad++;
          $display("FAIL b2b count got=%0d want=100", got);
        end
      end
    join
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b leftover got=%0d want=0", exp_q.size());
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_state  = 16'h0000;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_mid_reset;
    test_single;
    test_vectors;
    test_bypass;
    test_stall;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
